calendar_clock_core: RTL

- Parametrised successor to the seconds-to-years time/date counter.
- Adds an internal prescaler and correct month-length and leap-year handling (Gregorian or simple 4-year rule).
- Adds a set mode for field-by-field adjustment and packed-BCD outputs for downstream 7-segment decoders.
- Sits between the board clock and the display-decode layer.

---
 rtl/calendar_clock_core_if.sv | 34 +++
 rtl/calendar_clock_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/calendar_clock_core_if.sv
`default_nettype none
// ============================================================================
// Module   : calendar_clock_core_if
// Brief    : Control and display bus of the calendar clock core. The master
//            drives mode, field select and increment requests. The slave
//            returns the packed-BCD time/date and the tick/rollover pulses.
// Revision : 1.0 - initial release
// ============================================================================
interface calendar_clock_core_if;
    logic        mode;
    logic [2:0]  set_field;
    logic        inc;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic [7:0]  hour_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  month_bcd;
    logic [15:0] year_bcd;
    logic        tick;
    logic        rollover;

    modport master (
        output mode, set_field, inc,
        input  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd, year_bcd,
        input  tick, rollover
    );

    modport slave (
        input  mode, set_field, inc,
        output sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd, year_bcd,
        output tick, rollover
    );
endinterface
`default_nettype wire

// File: rtl/calendar_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : calendar_clock_core
// Brief    : Seconds-to-years calendar clock with an internal prescaler,
//            month-length and leap-year handling, a field-by-field set mode
//            and packed-BCD outputs for 7-segment decoders.
// Revision : 1.0 - initial release
// ============================================================================
module calendar_clock_core #(
    parameter int CLK_DIV    = 50000000,
    parameter int RESET_YEAR = 2024,
    parameter int YEAR_MAX   = 9999,
    parameter int GREGORIAN  = 1
) (
    input wire                    clk,
    input wire                    rst_n,
    calendar_clock_core_if.slave  bus
);

    localparam int               c_PW         = $clog2(CLK_DIV);
    localparam logic [c_PW-1:0]  c_PRESC_LAST = c_PW'(CLK_DIV - 1);
    localparam logic [c_PW-1:0]  c_PRESC_ONE  = c_PW'(1);
    localparam logic [13:0]      c_YEAR_MAX   = 14'(YEAR_MAX);
    localparam logic [13:0]      c_RESET_YEAR = 14'(RESET_YEAR);

    logic [c_PW-1:0] r_presc;
    logic [5:0]      r_sec;
    logic [5:0]      r_min;
    logic [4:0]      r_hour;
    logic [4:0]      r_day;
    logic [3:0]      r_month;
    logic [13:0]     r_year;
    logic            r_tick;
    logic            r_rollover;

    logic            w_tick;
    logic            w_roll;
    logic [5:0]      w_sec_n;
    logic [5:0]      w_min_n;
    logic [4:0]      w_hour_n;
    logic [4:0]      w_day_n;
    logic [3:0]      w_month_n;
    logic [13:0]     w_year_n;
    logic [4:0]      w_dim_cur;
    logic [4:0]      w_dim_n;

    function automatic logic is_leap(input logic [13:0] y);
        logic leap;
        if (GREGORIAN != 0)
            leap = (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) ||
                   ((y % 14'd400) == 14'd0);
        else
            leap = (y % 14'd4) == 14'd0;
        return leap;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
        logic [4:0] d;
        case (m)
            4'd2:                      d = is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
            default:                   d = 5'd31;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [15:0] bcd4(input logic [13:0] y);
        return {4'(y / 14'd1000), 4'((y / 14'd100) % 14'd10),
                4'((y / 14'd10) % 14'd10), 4'(y % 14'd10)};
    endfunction

    // Internal one-second strobe: only counts while running.
    assign w_tick    = !bus.mode && (r_presc == c_PRESC_LAST);
    assign w_dim_cur = days_in_month(r_month, r_year);

    // Next-state of all time/date fields: rippling carry on tick, or a single
    // wrapped field increment in set mode followed by the day clamp.
    always_comb begin
        w_sec_n   = r_sec;
        w_min_n   = r_min;
        w_hour_n  = r_hour;
        w_day_n   = r_day;
        w_month_n = r_month;
        w_year_n  = r_year;
        w_roll    = 1'b0;
        w_dim_n   = w_dim_cur;
        if (w_tick) begin
            if (r_sec != 6'd59) begin
                w_sec_n = r_sec + 6'd1;
            end else begin
                w_sec_n = 6'd0;
                if (r_min != 6'd59) begin
                    w_min_n = r_min + 6'd1;
                end else begin
                    w_min_n = 6'd0;
                    if (r_hour != 5'd23) begin
                        w_hour_n = r_hour + 5'd1;
                    end else begin
                        w_hour_n = 5'd0;
                        w_roll   = 1'b1;
                        if (r_day != w_dim_cur) begin
                            w_day_n = r_day + 5'd1;
                        end else begin
                            w_day_n = 5'd1;
                            if (r_month != 4'd12) begin
                                w_month_n = r_month + 4'd1;
                            end else begin
                                w_month_n = 4'd1;
                                w_year_n  = (r_year >= c_YEAR_MAX) ? 14'd0 : r_year + 14'd1;
                            end
                        end
                    end
                end
            end
        end else if (bus.mode && bus.inc) begin
            case (bus.set_field)
                3'd0:    w_sec_n   = (r_sec   >= 6'd59)     ? 6'd0  : r_sec + 6'd1;
                3'd1:    w_min_n   = (r_min   >= 6'd59)     ? 6'd0  : r_min + 6'd1;
                3'd2:    w_hour_n  = (r_hour  >= 5'd23)     ? 5'd0  : r_hour + 5'd1;
                3'd3:    w_day_n   = (r_day   >= w_dim_cur) ? 5'd1  : r_day + 5'd1;
                3'd4:    w_month_n = (r_month >= 4'd12)     ? 4'd1  : r_month + 4'd1;
                3'd5:    w_year_n  = (r_year  >= c_YEAR_MAX) ? 14'd0 : r_year + 14'd1;
                default: ;
            endcase
            // A shorter month or a non-leap February pulls the day down.
            w_dim_n = days_in_month(w_month_n, w_year_n);
            if (w_day_n > w_dim_n)
                w_day_n = w_dim_n;
        end
    end

    // Prescaler: free-runs in run mode, parked at zero in set mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_presc <= '0;
        else if (bus.mode || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + c_PRESC_ONE;
    end

    // Time/date registers and the registered tick/rollover pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec      <= 6'd0;
            r_min      <= 6'd0;
            r_hour     <= 5'd0;
            r_day      <= 5'd1;
            r_month    <= 4'd1;
            r_year     <= c_RESET_YEAR;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_sec      <= w_sec_n;
            r_min      <= w_min_n;
            r_hour     <= w_hour_n;
            r_day      <= w_day_n;
            r_month    <= w_month_n;
            r_year     <= w_year_n;
            r_tick     <= w_tick;
            r_rollover <= w_roll;
        end
    end

    assign bus.sec_bcd   = bcd2({1'b0, r_sec});
    assign bus.min_bcd   = bcd2({1'b0, r_min});
    assign bus.hour_bcd  = bcd2({2'b0, r_hour});
    assign bus.day_bcd   = bcd2({2'b0, r_day});
    assign bus.month_bcd = bcd2({3'b0, r_month});
    assign bus.year_bcd  = bcd4(r_year);
    assign bus.tick      = r_tick;
    assign bus.rollover  = r_rollover;

endmodule
`default_nettype wire
